// File: rtl/univ_shift_reg_if.sv
// Bundle of control, data and status signals for univ_shift_reg.
// The master drives the operation controls; the slave returns the register state.
interface univ_shift_reg_if #(
    parameter int WIDTH = 8
);
    logic             clear;
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sin_r;
    logic             sin_l;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qb;
    logic             word_done;

    modport master (
        output clear, en, mode, d, sin_r, sin_l,
        input  q, qb, word_done
    );

    modport slave (
        input  clear, en, mode, d, sin_r, sin_l,
        output q, qb, word_done
    );
endinterface

// File: rtl/univ_shift_reg.sv
// Multi-mode WIDTH-bit register: hold, shift, rotate, load, arithmetic shift and
// toggle, with complementary output and a pulse at each completed serial word.
module univ_shift_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    univ_shift_reg_if.slave  bus
);
    localparam int               CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_SHR  = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_ROR  = 3'b011;
    localparam logic [2:0] M_ROL  = 3'b100;
    localparam logic [2:0] M_LOAD = 3'b101;
    localparam logic [2:0] M_ASR  = 3'b110;
    localparam logic [2:0] M_TOG  = 3'b111;

    logic [WIDTH-1:0] q_p0;
    logic [CNT_W-1:0] cnt_p0;
    logic             word_done_p0;
    logic             is_shift;

    // Shifts are written as whole-word operations so WIDTH=1 needs no special
    // case: the incoming bit lands in bit 0, and rotates/ASR reduce to hold.
    function automatic logic [WIDTH-1:0] next_q(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] load,
        input logic             in_r,
        input logic             in_l
    );
        logic [WIDTH-1:0]        top_sin;
        logic [WIDTH-1:0]        top_lsb;
        logic [WIDTH-1:0]        low_msb;
        logic [WIDTH-1:0]        low_sin;
        logic signed [WIDTH-1:0] scur;
        logic [WIDTH-1:0]        res;
        top_sin = '0;
        top_sin[WIDTH-1] = in_r;
        top_lsb = '0;
        top_lsb[WIDTH-1] = cur[0];
        low_msb = '0;
        low_msb[0] = cur[WIDTH-1];
        low_sin = '0;
        low_sin[0] = in_l;
        scur = $signed(cur);
        case (op)
            M_SHR:   res = (cur >> 1) | top_sin;
            M_SHL:   res = (cur << 1) | low_sin;
            M_ROR:   res = (cur >> 1) | top_lsb;
            M_ROL:   res = (cur << 1) | low_msb;
            M_LOAD:  res = load;
            M_ASR:   res = $unsigned(scur >>> 1);
            M_TOG:   res = ~cur;
            default: res = cur;
        endcase
        return res;
    endfunction

    always_comb begin
        is_shift = 1'b0;
        case (bus.mode)
            M_SHR, M_SHL, M_ROR, M_ROL, M_ASR: is_shift = 1'b1;
            default:                           is_shift = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_p0         <= RESET_VAL;
            cnt_p0       <= '0;
            word_done_p0 <= 1'b0;
        end else if (bus.clear) begin
            q_p0         <= RESET_VAL;
            cnt_p0       <= '0;
            word_done_p0 <= 1'b0;
        end else begin
            word_done_p0 <= 1'b0;
            if (bus.en) begin
                q_p0 <= next_q(bus.mode, q_p0, bus.d, bus.sin_r, bus.sin_l);
                if (bus.mode == M_LOAD) begin
                    cnt_p0 <= '0;
                end else if (is_shift) begin
                    if (cnt_p0 == LAST) begin
                        cnt_p0       <= '0;
                        word_done_p0 <= 1'b1;
                    end else begin
                        cnt_p0 <= cnt_p0 + 1'b1;
                    end
                end
            end
        end
    end

    // qb follows q directly so it stays complementary even while reset is held.
    assign bus.q         = q_p0;
    assign bus.qb        = ~q_p0;
    assign bus.word_done = word_done_p0;

    logic unused_hold;
    assign unused_hold = (M_HOLD == 3'b000);
endmodule
